// File: rtl/norm_round_pkg.sv
// Shared types and helpers for the multi-lane normalise/round pipeline.
package norm_round_pkg;

   // Rounding mode carried with every beat; the reserved code behaves as RNE.
   typedef enum logic [1:0] {
      RND_RNE   = 2'd0,
      RND_FLOOR = 2'd1,
      RND_CEIL  = 2'd2,
      RND_RSVD  = 2'd3
   } rnd_mode_e;

   // Exponent bias of the wide input format.
   function automatic int bias_in(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // Exponent bias of the narrow output format.
   function automatic int bias_out(input int ew_out);
      return (1 << (ew_out - 1)) - 1;
   endfunction

   // LSB position of a lane inside a packed multi-lane bus.
   function automatic int lane_lsb(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

endpackage

// File: rtl/norm_round_lane.sv
// One lane of the datapath: S1 leading-sign normalise and rebias,
// S2 round, post-round renormalise and range saturate/flush.
// Load enables come from the shared handshake chain in the top.
module norm_round_lane
   import norm_round_pkg::*;
#(
   parameter int EW     = 10,
   parameter int MW     = 19,
   parameter int EW_OUT = 8,
   parameter int MW_OUT = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld1_i,
   input  logic              ld2_i,
   input  logic [EW-1:0]     e_i,
   input  logic [MW-1:0]     m_i,
   input  rnd_mode_e         mode_i,
   output logic [EW_OUT-1:0] e_out_o,
   output logic [MW_OUT-1:0] m_out_o,
   output logic              ovf_o,
   output logic              unf_o
);

   localparam int SW = $clog2(MW);
   localparam int XW = EW + 2;
   localparam logic signed [XW-1:0] ADJ   = XW'(bias_in(EW) - bias_out(EW_OUT));
   localparam logic signed [XW-1:0] E_MAX = XW'((1 << EW_OUT) - 1);
   localparam logic signed [XW-1:0] E_ONE = XW'(1);
   localparam logic [MW_OUT-1:0] M_POS_ONE = {2'b01, {(MW_OUT-2){1'b0}}};
   localparam logic [MW_OUT-1:0] M_NEG_ONE = {1'b1, {(MW_OUT-1){1'b0}}};
   localparam logic [MW_OUT-1:0] M_POS_MAX = {1'b0, {(MW_OUT-1){1'b1}}};

   logic [SW-1:0]          lsd_s;
   logic                   run_s;
   logic [MW-1:0]          mn_d, mn_q;
   logic signed [XW-1:0]   et_d, et_q;
   logic                   zero_d, zero_q;

   logic [MW_OUT-1:0]      keep_s, rnd_s, m_adj_s;
   logic                   guard_s, sticky_s, inc_s;
   logic signed [XW-1:0]   e_adj_s;
   logic [EW_OUT-1:0]      e_out_d, e_out_q;
   logic [MW_OUT-1:0]      m_out_d, m_out_q;
   logic                   ovf_d, ovf_q, unf_d, unf_q;

   // S1: count redundant sign bits (capped at MW-2), shift them out, rebias exponent.
   always_comb begin
      lsd_s = {SW{1'b0}};
      run_s = 1'b1;
      for (int k = 0; k < MW - 2; k++) begin
         if (run_s && (m_i[MW-2-k] == m_i[MW-1])) begin
            lsd_s = lsd_s + SW'(1);
         end else begin
            run_s = 1'b0;
         end
      end
      mn_d   = m_i << lsd_s;
      et_d   = $signed({2'b00, e_i}) - $signed({{(XW-SW){1'b0}}, lsd_s}) - ADJ;
      zero_d = (m_i == {MW{1'b0}});
   end

   // S1 register: normalised mantissa, signed exponent, zero marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mn_q   <= {MW{1'b0}};
         et_q   <= {XW{1'b0}};
         zero_q <= 1'b0;
      end else if (ld1_i) begin
         mn_q   <= mn_d;
         et_q   <= et_d;
         zero_q <= zero_d;
      end
   end

   // S2: round, renormalise the two overflow shapes of the increment, then range-check.
   always_comb begin
      keep_s   = mn_q[MW-1 -: MW_OUT];
      guard_s  = mn_q[MW-MW_OUT-1];
      sticky_s = |mn_q[MW-MW_OUT-2:0];
      case (mode_i)
         RND_FLOOR: inc_s = 1'b0;
         RND_CEIL:  inc_s = guard_s | sticky_s;
         default:   inc_s = guard_s & (sticky_s | keep_s[0]);
      endcase
      rnd_s = keep_s + {{(MW_OUT-1){1'b0}}, inc_s};
      if (!keep_s[MW_OUT-1] && rnd_s[MW_OUT-1]) begin
         // 0111..1 + 1 wrapped to negative: value is exactly 1.0
         m_adj_s = M_POS_ONE;
         e_adj_s = et_q + E_ONE;
      end else if (rnd_s[MW_OUT-1] && rnd_s[MW_OUT-2]) begin
         // negative with two leading ones is -0.5: express as -1.0 one octave down
         m_adj_s = M_NEG_ONE;
         e_adj_s = et_q - E_ONE;
      end else begin
         m_adj_s = rnd_s;
         e_adj_s = et_q;
      end
      if (zero_q) begin
         e_out_d = {EW_OUT{1'b0}};
         m_out_d = {MW_OUT{1'b0}};
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (e_adj_s > E_MAX) begin
         e_out_d = {EW_OUT{1'b1}};
         m_out_d = keep_s[MW_OUT-1] ? M_NEG_ONE : M_POS_MAX;
         ovf_d   = 1'b1;
         unf_d   = 1'b0;
      end else if (e_adj_s < E_ONE) begin
         e_out_d = {EW_OUT{1'b0}};
         m_out_d = {MW_OUT{1'b0}};
         ovf_d   = 1'b0;
         unf_d   = 1'b1;
      end else begin
         e_out_d = e_adj_s[EW_OUT-1:0];
         m_out_d = m_adj_s;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end
   end

   // S2 register: rounded lane result and its range flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_out_q <= {EW_OUT{1'b0}};
         m_out_q <= {MW_OUT{1'b0}};
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (ld2_i) begin
         e_out_q <= e_out_d;
         m_out_q <= m_out_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign e_out_o = e_out_q;
   assign m_out_o = m_out_q;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

endmodule

// File: rtl/norm_round_pipe.sv
// Multi-lane pipelined normaliser/rounder: S1 normalise, S2 round, S3 output,
// one valid/ready handshake shared by all lanes, sticky overflow status.
module norm_round_pipe
   import norm_round_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int EW     = 10,
   parameter int MW     = 19,
   parameter int EW_OUT = 8,
   parameter int MW_OUT = 9
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [1:0]                     rnd_mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [LANES*(EW+MW)-1:0]       in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES*(EW_OUT+MW_OUT)-1:0] out_data,
   output logic [LANES-1:0]               out_ovf,
   output logic [LANES-1:0]               out_unf,
   output logic                           sts_ovf,
   input  logic                           sts_clr
);

   localparam int IW = EW + MW;
   localparam int OW = EW_OUT + MW_OUT;

   logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
   logic en1_s, en2_s, en3_s, ld1_s, ld2_s, ld3_s;
   rnd_mode_e mode1_d, mode1_q;

   logic [EW_OUT-1:0] lane_e_s [LANES];
   logic [MW_OUT-1:0] lane_m_s [LANES];
   logic [LANES-1:0]  lane_ovf_s, lane_unf_s;

   logic [LANES*OW-1:0] out_data_d, out_data_q;
   logic [LANES-1:0]    out_ovf_d, out_ovf_q, out_unf_d, out_unf_q;
   logic                sts_ovf_d, sts_ovf_q;

   // Valid chain: a stage loads when empty or when its contents move on this cycle.
   always_comb begin
      en3_s   = !v3_q | out_ready;
      en2_s   = !v2_q | en3_s;
      en1_s   = !v1_q | en2_s;
      ld1_s   = en1_s & in_valid;
      ld2_s   = en2_s & v1_q;
      ld3_s   = en3_s & v2_q;
      v1_d    = en1_s ? in_valid : v1_q;
      v2_d    = en2_s ? v1_q : v2_q;
      v3_d    = en3_s ? v2_q : v3_q;
      mode1_d = ld1_s ? rnd_mode_e'(rnd_mode) : mode1_q;
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      localparam int LSB = lane_lsb(g, IW);
      norm_round_lane #(
         .EW     (EW),
         .MW     (MW),
         .EW_OUT (EW_OUT),
         .MW_OUT (MW_OUT)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .ld1_i   (ld1_s),
         .ld2_i   (ld2_s),
         .e_i     (in_data[LSB+MW +: EW]),
         .m_i     (in_data[LSB +: MW]),
         .mode_i  (mode1_q),
         .e_out_o (lane_e_s[g]),
         .m_out_o (lane_m_s[g]),
         .ovf_o   (lane_ovf_s[g]),
         .unf_o   (lane_unf_s[g])
      );
   end

   // S3 output staging (held while stalled) and sticky overflow, where clear beats set.
   always_comb begin
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      out_unf_d  = out_unf_q;
      if (ld3_s) begin
         for (int i = 0; i < LANES; i++) begin
            out_data_d[i*OW +: OW] = {lane_e_s[i], lane_m_s[i]};
         end
         out_ovf_d = lane_ovf_s;
         out_unf_d = lane_unf_s;
      end else begin
         out_data_d = out_data_q;
      end
      if (sts_clr) begin
         sts_ovf_d = 1'b0;
      end else if (v3_q && out_ready && (|out_ovf_q)) begin
         sts_ovf_d = 1'b1;
      end else begin
         sts_ovf_d = sts_ovf_q;
      end
   end

   // Pipeline control, output stage and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         mode1_q    <= RND_RNE;
         out_data_q <= {(LANES*OW){1'b0}};
         out_ovf_q  <= {LANES{1'b0}};
         out_unf_q  <= {LANES{1'b0}};
         sts_ovf_q  <= 1'b0;
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         v3_q       <= v3_d;
         mode1_q    <= mode1_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
         out_unf_q  <= out_unf_d;
         sts_ovf_q  <= sts_ovf_d;
      end
   end

   assign in_ready  = en1_s;
   assign out_valid = v3_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_unf   = out_unf_q;
   assign sts_ovf   = sts_ovf_q;

endmodule

// File: tb/tb_norm_round_pipe.sv
// Bench for norm_round_pipe: directed test-plan vectors, sticky status,
// randomized stalled traffic against an arithmetic reference, mid-flight reset.
module tb_norm_round_pipe;

   localparam int LANES = 4, EW = 10, MW = 19, EW_OUT = 8, MW_OUT = 9;
   localparam int IW = EW + MW, OW = EW_OUT + MW_OUT;

   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, out_valid, out_ready, sts_ovf, sts_clr;
   logic [1:0] rnd_mode;
   logic [LANES*IW-1:0] in_data;
   logic [LANES*OW-1:0] out_data;
   logic [LANES-1:0] out_ovf, out_unf;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [LANES*OW-1:0] d;
      logic [LANES-1:0]    o;
      logic [LANES-1:0]    u;
   } beat_t;
   beat_t sb[$];
   beat_t exp_b, held;
   logic  stall_p, acc, xfer;
   int    acc_cnt, out_cnt, cyc;

   always #5 clk = ~clk;

   norm_round_pipe #(.LANES(LANES), .EW(EW), .MW(MW), .EW_OUT(EW_OUT), .MW_OUT(MW_OUT)) dut (
      .clk(clk), .rst_n(rst_n), .rnd_mode(rnd_mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .out_unf(out_unf), .sts_ovf(sts_ovf), .sts_clr(sts_clr)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: value = m * 2^(e-BIAS) in plain integers; returns {ovf, unf, e_out, m_out}.
   function automatic logic [18:0] ref_lane(input logic [9:0] e, input logic [18:0] m, input logic [1:0] mode);
      int mv, ex, q, r, inc;
      logic [7:0] eo;
      logic [8:0] mo;
      mv = int'($signed(m));
      if (mv == 0) return 19'd0;
      ex = int'(e) - 511 + 127;
      if (mv > 0) begin
         while (mv < 131072) begin mv = mv * 2; ex--; end
      end else begin
         while (mv >= -131072) begin mv = mv * 2; ex--; end
      end
      q = mv >>> 10;
      r = mv - q * 1024;
      case (mode)
         2'd1:    inc = 0;
         2'd2:    inc = (r != 0) ? 1 : 0;
         default: inc = ((r > 512) || (r == 512 && (q & 1) != 0)) ? 1 : 0;
      endcase
      q = q + inc;
      if (q == 256) begin q = 128; ex++; end
      else if (q == -128) begin q = -256; ex--; end
      if (ex > 255) return {1'b1, 1'b0, 8'hFF, (mv > 0) ? 9'h0FF : 9'h100};
      if (ex < 1) return {1'b0, 1'b1, 17'd0};
      eo = ex[7:0];
      mo = q[8:0];
      return {2'b00, eo, mo};
   endfunction

   function automatic beat_t ref_beat(input logic [LANES*IW-1:0] din, input logic [1:0] mode);
      beat_t b;
      logic [18:0] r;
      b.d = '0; b.o = '0; b.u = '0;
      for (int i = 0; i < LANES; i++) begin
         r = ref_lane(din[i*IW+MW +: EW], din[i*IW +: MW], mode);
         b.d[i*OW +: OW] = r[16:0];
         b.o[i] = r[18];
         b.u[i] = r[17];
      end
      return b;
   endfunction

   task automatic rand_data();
      logic signed [18:0] ms;
      for (int i = 0; i < LANES; i++) begin
         if ($urandom_range(0, 9) < 8) in_data[i*IW+MW +: EW] = 10'($urandom_range(380, 650));
         else                          in_data[i*IW+MW +: EW] = 10'($urandom_range(0, 1023));
         ms = 19'($urandom());
         if ($urandom_range(0, 3) == 0) ms = ms >>> $urandom_range(0, 18);
         if ($urandom_range(0, 15) == 0) ms = 19'sd0;
         in_data[i*IW +: MW] = ms;
      end
   endtask

   task automatic directed(input string tag, input logic [9:0] e, input logic [18:0] m, input logic [1:0] mode,
                           input logic [7:0] xe, input logic [8:0] xm, input logic xo, input logic xu);
      int lat;
      in_data = '0;
      in_data[MW +: EW] = e;
      in_data[0 +: MW]  = m;
      rnd_mode  = mode;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, 3);
      check({tag, " e_out"}, out_data[MW_OUT +: EW_OUT], xe);
      check({tag, " m_out"}, out_data[0 +: MW_OUT], xm);
      check({tag, " ovf"}, out_ovf[0], xo);
      check({tag, " unf"}, out_unf[0], xu);
      check({tag, " other lanes"}, {out_data[LANES*OW-1:OW], out_ovf[LANES-1:1], out_unf[LANES-1:1]}, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rnd_mode = 2'd0; out_ready = 1'b0; sts_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("valid in reset", out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset outputs", {out_data, out_ovf, out_unf, sts_ovf}, 0);

      directed("norm shift",  10'd511,  19'h10000, 2'd0, 8'd126, 9'h080, 1'b0, 1'b0);
      directed("rne up",      10'd511,  19'h20600, 2'd0, 8'd127, 9'h082, 1'b0, 1'b0);
      directed("rne tie even",10'd511,  19'h20200, 2'd0, 8'd127, 9'h080, 1'b0, 1'b0);
      directed("ceil",        10'd511,  19'h20200, 2'd2, 8'd127, 9'h081, 1'b0, 1'b0);
      directed("floor",       10'd511,  19'h20200, 2'd1, 8'd127, 9'h080, 1'b0, 1'b0);
      directed("reserved",    10'd511,  19'h20600, 2'd3, 8'd127, 9'h082, 1'b0, 1'b0);
      directed("pos carry",   10'd511,  19'h3FE00, 2'd0, 8'd128, 9'h080, 1'b0, 1'b0);
      directed("neg renorm",  10'd511,  19'h5FE00, 2'd0, 8'd126, 9'h100, 1'b0, 1'b0);
      directed("zero",        10'd600,  19'h00000, 2'd0, 8'd0,   9'h000, 1'b0, 1'b0);
      check("sts before ovf", sts_ovf, 0);
      directed("pos ovf",     10'd1023, 19'h20000, 2'd0, 8'hFF,  9'h0FF, 1'b1, 1'b0);
      check("sts set", sts_ovf, 1);
      directed("unf",         10'd10,   19'h20000, 2'd0, 8'd0,   9'h000, 1'b0, 1'b1);
      check("sts sticky", sts_ovf, 1);
      sts_clr = 1'b1;
      @(posedge clk); #1;
      sts_clr = 1'b0;
      check("sts cleared", sts_ovf, 0);
      directed("neg ovf",     10'd1023, 19'h40000, 2'd0, 8'hFF,  9'h100, 1'b1, 1'b0);
      sts_clr = 1'b1;
      @(posedge clk); #1;
      sts_clr = 1'b0;

      // Stalled overflow beat, then transfer and clear in the same cycle: clear wins.
      out_ready = 1'b0;
      in_data = '0;
      in_data[MW +: EW] = 10'd1023;
      in_data[0 +: MW]  = 19'h20000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("stall valid", out_valid, 1);
      check("stall ovf", out_ovf, 4'b0001);
      check("stall data", out_data[OW-1:0], {8'hFF, 9'h0FF});
      out_ready = 1'b1;
      sts_clr = 1'b1;
      @(posedge clk); #1;
      sts_clr = 1'b0;
      check("clear wins", sts_ovf, 0);
      check("stall drained", out_valid, 0);

      // Random traffic with 50% output stalls.
      acc_cnt = 0; out_cnt = 0; cyc = 0; stall_p = 1'b0;
      held.d = '0; held.o = '0; held.u = '0;
      while ((acc_cnt < 500 || sb.size() > 0) && cyc < 6000) begin
         if (stall_p) begin
            check("hold valid", out_valid, 1);
            check("hold data", {out_data, out_ovf, out_unf}, {held.d, held.o, held.u});
         end
         in_valid = (acc_cnt < 500) ? ($urandom_range(0, 9) < 7) : 1'b0;
         rand_data();
         rnd_mode  = 2'($urandom_range(0, 3));
         out_ready = (acc_cnt < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         acc  = in_valid & in_ready;
         xfer = out_valid & out_ready;
         stall_p = out_valid & !out_ready;
         held.d = out_data; held.o = out_ovf; held.u = out_unf;
         if (xfer) begin
            check("beat expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               exp_b = sb.pop_front();
               check("beat data", out_data, exp_b.d);
               check("beat ovf", out_ovf, exp_b.o);
               check("beat unf", out_unf, exp_b.u);
            end
            out_cnt++;
         end
         if (acc) begin
            sb.push_back(ref_beat(in_data, rnd_mode));
            acc_cnt++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("beats accepted", acc_cnt, 500);
      check("beats delivered", out_cnt, 500);
      check("scoreboard empty", sb.size(), 0);

      // Reset with three beats in flight.
      out_ready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         rand_data();
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("full before reset", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("async reset valid", out_valid, 0);
      @(posedge clk); #1;
      check("reset next cycle", out_valid, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post reset in_ready", in_ready, 1);
      for (int c = 0; c < 6; c++) begin
         check("no stale beat", out_valid, 0);
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
